// File: rtl/instr_encoder_loader.sv
// Encodes per-field RV32I instruction descriptions into 32-bit words and streams them
// through a small FIFO into instruction memory under a start/count/done sequencer.
module instr_encoder_loader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [31:0]       imm,
  output logic              imem_wr_valid,
  input  logic              imem_wr_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic              start_accept;
  logic [ADDR_W-1:0] base_addr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  acc_reg;
  logic [CNT_W-1:0]  wr_reg;
  logic              err_reg;

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    fill_reg;
  logic [31:0]       fifo_mem [DEPTH];
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  logic [31:0]       enc_word;
  logic              enc_illegal;

  // Field packing; illegal formats collapse to a NOP so the program length is preserved.
  always_comb begin
    enc_word    = NOP_WORD;
    enc_illegal = 1'b0;
    case (fmt)
      3'd0: enc_word = {func7, rs2, rs1, func3, rd, opcode};
      3'd1: begin
        if (opcode == 7'b0010011 && (func3 == 3'b001 || func3 == 3'b101))
          enc_word = {func7, imm[4:0], rs1, func3, rd, opcode};
        else
          enc_word = {imm[11:0], rs1, func3, rd, opcode};
      end
      3'd2: enc_word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      3'd3: enc_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      3'd4: enc_word = {imm[31:12], rd, opcode};
      3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: begin
        enc_word    = NOP_WORD;
        enc_illegal = 1'b1;
      end
    endcase
  end

  assign fifo_full  = (fill_reg == (PTR_W+1)'(DEPTH));
  assign fifo_empty = (fill_reg == '0);

  assign in_ready      = (state_reg == S_LOAD) && !fifo_full && (acc_reg < count_reg);
  assign push          = in_valid && in_ready;
  assign imem_wr_valid = !fifo_empty;
  assign pop           = imem_wr_valid && imem_wr_ready;
  // Head is masked while empty so the data bus idles at zero rather than stale entries.
  assign imem_wdata    = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_reg];
  assign imem_addr     = base_addr_reg + (ADDR_W'(wr_reg) << 2);

  assign busy = (state_reg != S_IDLE);
  assign done = (state_reg == S_DONE);
  assign err  = err_reg;

  always_comb begin
    state_next   = state_reg;
    start_accept = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_next   = (count == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (wr_reg == count_reg)
          state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      base_addr_reg <= '0;
      count_reg     <= '0;
      acc_reg       <= '0;
      wr_reg        <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_accept) begin
        base_addr_reg <= start_addr;
        count_reg     <= count;
        acc_reg       <= '0;
        wr_reg        <= '0;
        err_reg       <= 1'b0;
      end else begin
        if (push)
          acc_reg <= acc_reg + CNT_W'(1);
        if (pop)
          wr_reg <= wr_reg + CNT_W'(1);
        if (push && enc_illegal)
          err_reg <= 1'b1;
      end
    end
  end

  // Pointer/fill state is reset so an aborted load leaves nothing to drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)
        fill_reg <= fill_reg + (PTR_W+1)'(1);
      else if (pop && !push)
        fill_reg <= fill_reg - (PTR_W+1)'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi)))
          fifo_mem[gi] <= enc_word;
      end
    end
  endgenerate

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: hand-encoded RV32I vectors, backpressure,
// illegal formats, zero-length loads, ignored starts and mid-load reset.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic [15:0] count = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  func7 = '0;
  logic [31:0] imm = '0;
  logic        imem_wr_valid;
  logic        imem_wr_ready = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err;

  int errors = 0;
  int checks = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int done_cnt = 0;
  int acc_cnt = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(32), .CNT_W(16), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .func7(func7), .imm(imm),
    .imem_wr_valid(imem_wr_valid), .imem_wr_ready(imem_wr_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  // Observe handshakes shortly before each rising edge, well away from it.
  always @(negedge clk) begin
    #4;
    if (imem_wr_valid && imem_wr_ready) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
    if (in_valid && in_ready) acc_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  task automatic do_start(input logic [31:0] a, input logic [15:0] n);
    start = 1'b1; start_addr = a; count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; func7 = f7; imm = im;
  endtask

  // Hold in_valid until accepted (bounded); returns at the negedge after the handshake.
  task automatic push_wait(input string tag);
    int t = 0;
    in_valid = 1'b1;
    while (1) begin
      #4;
      if (in_ready) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
      t++;
      if (t > 60) begin
        check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic [2:0] f, input logic [6:0] op,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    set_fields(f, op, d, s1, s2, f3, f7, im);
    push_wait(tag);
  endtask

  task automatic wait_done(input string tag, input int base);
    int t = 0;
    while (done_cnt == base && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, 32'(t < 100), 32'd1);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] a,
                             input logic [31:0] d);
    if (wa_q.size() > idx) begin
      check({tag, "_addr"}, wa_q[idx], a);
      check({tag, "_data"}, wd_q[idx], d);
    end else begin
      check({tag, "_present"}, 32'(wa_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int base, nw, acc0;
    logic [31:0] hold_a, hold_d;
    logic stable;

    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_valid", 32'(imem_wr_valid), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single R-type: add x3,x1,x2
    base = done_cnt;
    do_start(32'h100, 16'd1);
    check("r_busy", 32'(busy), 32'd1);
    send("r", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    check("r_valid_next", 32'(imem_wr_valid), 32'd1);
    check("r_wdata_next", imem_wdata, 32'h002081B3);
    check("r_addr_next", imem_addr, 32'h100);
    wait_done("r", base);
    check("r_done_pulse", 32'(done), 32'd0);
    check("r_idle", 32'(busy), 32'd0);
    check("r_nwrites", 32'(wd_q.size()), 32'd1);
    check_write("r_w0", 0, 32'h100, 32'h002081B3);

    // I/S/B sequence
    nw = wd_q.size(); base = done_cnt;
    do_start(32'h200, 16'd3);
    send("addi", 3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    send("sw",   3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    send("beq",  3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    wait_done("isb", base);
    check("isb_nwrites", 32'(wd_q.size() - nw), 32'd3);
    check_write("isb_w0", nw,     32'h200, 32'hFFF00293);
    check_write("isb_w1", nw + 1, 32'h204, 32'h0020A423);
    check_write("isb_w2", nw + 2, 32'h208, 32'hFE208EE3);

    // U/J and I-type shift
    nw = wd_q.size(); base = done_cnt;
    do_start(32'h300, 16'd3);
    send("lui",  3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    send("jal",  3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    send("srai", 3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3);
    wait_done("uj", base);
    check_write("uj_w0", nw,     32'h300, 32'h123453B7);
    check_write("uj_w1", nw + 1, 32'h304, 32'h008000EF);
    check_write("uj_w2", nw + 2, 32'h308, 32'h4030D093);

    // Backpressure: FIFO fills to DEPTH, output held stable, then drains in order
    nw = wd_q.size(); base = done_cnt;
    imem_wr_ready = 1'b0;
    do_start(32'h400, 16'd4);
    acc0 = acc_cnt;
    set_fields(3'd0, 7'h33, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    push_wait("bp_a");
    set_fields(3'd0, 7'h33, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    push_wait("bp_b");
    set_fields(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    #1;
    hold_a = imem_addr; hold_d = imem_wdata; stable = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      if (imem_addr !== hold_a || imem_wdata !== hold_d || in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_accepted", 32'(acc_cnt - acc0), 32'd2);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_hold_addr", hold_a, 32'h400);
    check("bp_hold_data", hold_d, 32'h002080B3);
    @(negedge clk);
    imem_wr_ready = 1'b1;
    push_wait("bp_c");
    send("bp_d", 3'd0, 7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    wait_done("bp", base);
    check("bp_nwrites", 32'(wd_q.size() - nw), 32'd4);
    for (int i = 0; i < 4; i++)
      check_write($sformatf("bp_w%0d", i), nw + i, 32'h400 + 32'(4 * i),
                  32'h00208033 | (32'(i + 1) << 7));

    // Illegal format among a two-word load
    nw = wd_q.size(); base = done_cnt;
    do_start(32'h500, 16'd2);
    send("il_addi", 3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    send("il_bad",  3'd7, 7'h33, 5'd9, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    wait_done("il", base);
    check_write("il_w0", nw,     32'h500, 32'hFFF00293);
    check_write("il_w1", nw + 1, 32'h504, 32'h00000013);
    repeat (3) @(negedge clk);
    check("il_err_sticky", 32'(err), 32'd1);

    // Zero-length load: done next cycle, no write, err cleared
    nw = wd_q.size();
    do_start(32'h900, 16'd0);
    check("z_done", 32'(done), 32'd1);
    check("z_err_clr", 32'(err), 32'd0);
    @(negedge clk);
    check("z_done_low", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("z_nwrites", 32'(wd_q.size() - nw), 32'd0);

    // Start while busy is ignored
    nw = wd_q.size(); base = done_cnt;
    do_start(32'h600, 16'd2);
    send("sb_0", 3'd0, 7'h33, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    do_start(32'h700, 16'd1);
    send("sb_1", 3'd0, 7'h33, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    wait_done("sb", base);
    repeat (3) @(negedge clk);
    check("sb_nwrites", 32'(wd_q.size() - nw), 32'd2);
    check("sb_ndone", 32'(done_cnt - base), 32'd1);
    check_write("sb_w0", nw,     32'h600, 32'h002080B3);
    check_write("sb_w1", nw + 1, 32'h604, 32'h00208133);

    // Asynchronous reset with a full FIFO mid-load
    nw = wd_q.size();
    imem_wr_ready = 1'b0;
    do_start(32'h800, 16'd4);
    send("rs_0", 3'd0, 7'h33, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send("rs_1", 3'd0, 7'h33, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_valid", 32'(imem_wr_valid), 32'd0);
    check("rs_addr", imem_addr, 32'h0);
    check("rs_wdata", imem_wdata, 32'h0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_wr_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("rs_nwrites", 32'(wd_q.size() - nw), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the main-decoder path: takes per-field RV32I instruction descriptions and encodes them into 32-bit instruction words. Writes the words sequentially into instruction memory through a buffered valid/ready write port. Used by the test/boot infrastructure to load programs before the single-cycle core runs. Holds a small FIFO between encoding and the memory write port, plus a start/count/done load sequencer.

Parameters:
ADDR_W, 32, instruction-memory byte-address width
CNT_W, 16, width of load count and internal counters
DEPTH, 2, encoded-word FIFO depth (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load (honoured only in IDLE)
start_addr  in  ADDR_W  byte address of first word (word-aligned)
count  in  CNT_W  number of instructions in this load
in_valid  in  1  field bundle valid
in_ready  out  1  field bundle accepted this cycle when in_valid&in_ready
fmt  in  3  0=R,1=I,2=S,3=B,4=U,5=J; 6,7 illegal
opcode  in  7  instr[6:0]
rd, rs1, rs2  in  5 each  register fields
func3  in  3  instr[14:12]
func7  in  7  instr[31:25] (R type, I-type shifts)
imm  in  32  immediate, already sign-extended/positioned per RV32I semantics
imem_wr_valid  out  1  write request
imem_wr_ready  in  1  memory accepts write this cycle
imem_addr  out  ADDR_W  write byte address
imem_wdata  out  32  encoded instruction
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at load completion
err  out  1  sticky illegal-fmt flag; cleared on an accepted start

Behaviour:
- Reset (async, rst_n=0): state IDLE; FIFO empty; counters 0; in_ready=0, imem_wr_valid=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0. A reset mid-load discards buffered words; no further writes are issued.
- FSM IDLE -> LOAD on start (latch start_addr, count; clear err; zero the accepted counter acc and written counter wr). If count==0: IDLE -> DONE directly. LOAD -> DONE when wr==count. DONE -> IDLE unconditionally; done=1 only in DONE. start outside IDLE is ignored.
- in_ready = (state==LOAD) & FIFO not full & (acc<count). in_ready is not raised on a same-cycle pop when the FIFO is full (no full-pop bypass).
- Encoding (combinational on inputs, pushed on handshake):
  - R: {func7,rs2,rs1,func3,rd,opcode}
  - I: {imm[11:0],rs1,func3,rd,opcode}; if opcode==0010011 and func3 is 001/101: {func7,imm[4:0],rs1,func3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,func3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],opcode}; imm[0] ignored
  - U: {imm[31:12],rd,opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
  - fmt 6/7: push NOP 0x00000013, set err; the entry counts toward acc/wr.
- FIFO: push on in handshake; pop on imem_wr_valid&imem_wr_ready. No empty bypass: a word accepted in cycle N appears on imem_wdata at N+1 at the earliest. Push and pop in the same cycle are allowed when not full.
- imem_wr_valid = FIFO not empty. imem_wdata is the FIFO head. imem_addr = start_addr + 4*wr. imem_wdata and imem_addr are held stable while imem_wr_valid=1 and imem_wr_ready=0. wr increments per pop; address wraps modulo 2^ADDR_W.
- acc never exceeds count; surplus in_valid after acc==count is left unaccepted.

Test Plan:
- Reset, start addr=0x100 count=1, R fmt op=0x33 rd=3 rs1=1 rs2=2 f3=0 f7=0 -> write 0x002081B3 @0x100 next cycle; done pulses one cycle after the write handshake.
- I/S/B sequence with count=3, imem_wr_ready=1: addi x5,x0,-1; sw x2,8(x1); beq x1,x2,imm=-4 -> 0xFFF00293@A, 0x0020A423@A+4, 0xFE208EE3@A+8.
- U/J plus shift: lui x7 imm=0x12345000 -> 0x123453B7; jal x1 imm=8 -> 0x008000EF; srai x1,x1,3 (f7=0x20) -> 0x4030D093.
- Backpressure: imem_wr_ready=0 for 5 cycles, in_valid=1 -> exactly DEPTH words accepted, in_ready=0 afterwards, addr/data stable; release -> in-order writes with no loss or duplication.
- fmt=7 among count=2 -> 0x00000013 written, err=1 until next start; count=0 start -> done next cycle, no write; start while busy ignored.
- rst_n low mid-load with FIFO full -> all outputs 0 immediately; no write after release.
